// File: rtl/servo_pkg.sv
// Shared constants and types for the three-servo PWM sequencer.
// Defaults assume a 50 MHz clock and a 20 ms frame.
package servo_pkg;

    localparam int DEF_FRAME_TICKS = 1000000;
    localparam int DEF_W_LEFT      = 50000;
    localparam int DEF_W_MID       = 75000;
    localparam int DEF_W_RIGHT     = 100000;
    localparam int DEF_HOLD_FRAMES = 50;
    localparam int DEF_GAP_FRAMES  = 50;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_MOVE,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        COL_RED     = 2'd0,
        COL_GREEN   = 2'd1,
        COL_BLUE    = 2'd2,
        COL_INVALID = 2'd3
    } col_t;

    typedef enum logic [1:0] {
        SRV_NONE,
        SRV_DISP,
        SRV_COL,
        SRV_LIFT
    } srv_t;

    // Counter width: enough for the frame, never narrower than 20 bits.
    function automatic int cnt_width(input int ticks);
        int w;
        w = $clog2(ticks);
        return (w < 20) ? 20 : w;
    endfunction

endpackage

// File: rtl/servo_frame_gen.sv
// Free-running PWM frame counter with wrap tick and width compare.
// The counter starts each frame at 0, so pulses begin on the wrap.
module servo_frame_gen
    import servo_pkg::*;
#(
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int CW          = 20
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [CW-1:0] i_width,
    output logic          o_tick,
    output logic          o_pulse
);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(FRAME_TICKS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick  = w_wrap;
    assign o_pulse = (r_cnt < i_width);

endmodule

// File: rtl/servo_sequencer.sv
// Sequences dispenser, colour and lift servo moves, one at a time,
// each as a burst of frame-aligned PWM pulses followed by idle frames.
module servo_sequencer
    import servo_pkg::*;
#(
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int W_LEFT      = DEF_W_LEFT,
    parameter int W_MID       = DEF_W_MID,
    parameter int W_RIGHT     = DEF_W_RIGHT,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int GAP_FRAMES  = DEF_GAP_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       col_req,
    input  logic [1:0] col_sel,
    input  logic       lift_req,
    output logic       pwm_disp,
    output logic       pwm_color,
    output logic       pwm_lift,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CW = cnt_width(FRAME_TICKS);

    state_t        r_state, w_state_nxt;
    srv_t          r_srv;
    col_t          r_col;
    logic [15:0]   r_frames, w_frames_nxt;
    logic [CW-1:0] r_width, w_target;
    logic          r_prev_go, r_prev_col, r_prev_lift;
    logic          r_pend_go, r_pend_col, r_pend_lift;
    logic          r_dir, r_lift, r_err;
    logic          w_go_rise, w_col_rise, w_lift_rise;
    logic          w_col_ok, w_col_bad;
    logic          w_gnt_disp, w_gnt_col, w_gnt_lift, w_gnt;
    logic          w_done, w_tick, w_pulse, w_move;

    assign w_go_rise   = go & ~r_prev_go;
    assign w_col_rise  = col_req & ~r_prev_col;
    assign w_lift_rise = lift_req & ~r_prev_lift;
    assign w_col_bad   = w_col_rise & (col_t'(col_sel) == COL_INVALID);
    assign w_col_ok    = w_col_rise & ~w_col_bad;

    servo_frame_gen #(
        .FRAME_TICKS(FRAME_TICKS),
        .CW         (CW)
    ) u_frame (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_width(r_width),
        .o_tick (w_tick),
        .o_pulse(w_pulse)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_frames_nxt = r_frames;
        w_gnt_disp   = 1'b0;
        w_gnt_col    = 1'b0;
        w_gnt_lift   = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend_lift) begin
                    w_gnt_lift  = 1'b1;
                    w_state_nxt = ST_ALIGN;
                end else if (r_pend_col) begin
                    w_gnt_col   = 1'b1;
                    w_state_nxt = ST_ALIGN;
                end else if (r_pend_go) begin
                    w_gnt_disp  = 1'b1;
                    w_state_nxt = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (w_tick) begin
                    w_state_nxt  = ST_MOVE;
                    w_frames_nxt = '0;
                end
            end
            ST_MOVE: begin
                if (w_tick) begin
                    if (r_frames == 16'(HOLD_FRAMES - 1)) begin
                        w_state_nxt  = ST_GAP;
                        w_frames_nxt = '0;
                    end else begin
                        w_frames_nxt = r_frames + 16'd1;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    if (r_frames == 16'(GAP_FRAMES - 1)) begin
                        w_state_nxt  = ST_IDLE;
                        w_frames_nxt = '0;
                        w_done       = 1'b1;
                    end else begin
                        w_frames_nxt = r_frames + 16'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_gnt = w_gnt_disp | w_gnt_col | w_gnt_lift;

    // Lift and dispenser targets come from the position they move to.
    always_comb begin
        w_target = '0;
        if (w_gnt_lift) begin
            w_target = r_lift ? CW'(W_LEFT) : CW'(W_RIGHT);
        end else if (w_gnt_col) begin
            case (r_col)
                COL_GREEN: w_target = CW'(W_MID);
                COL_BLUE:  w_target = CW'(W_RIGHT);
                default:   w_target = CW'(W_LEFT);
            endcase
        end else if (w_gnt_disp) begin
            w_target = r_dir ? CW'(W_RIGHT) : CW'(W_LEFT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_frames <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_frames <= w_frames_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_go   <= 1'b0;
            r_prev_col  <= 1'b0;
            r_prev_lift <= 1'b0;
            r_pend_go   <= 1'b0;
            r_pend_col  <= 1'b0;
            r_pend_lift <= 1'b0;
            r_col       <= COL_RED;
            r_dir       <= 1'b0;
            r_lift      <= 1'b0;
            r_err       <= 1'b0;
            r_srv       <= SRV_NONE;
            r_width     <= '0;
        end else begin
            r_prev_go   <= go;
            r_prev_col  <= col_req;
            r_prev_lift <= lift_req;
            r_pend_go   <= (r_pend_go & ~w_gnt_disp) | w_go_rise;
            r_pend_col  <= (r_pend_col & ~w_gnt_col) | w_col_ok;
            r_pend_lift <= (r_pend_lift & ~w_gnt_lift) | w_lift_rise;
            r_err       <= w_col_bad;
            if (w_col_ok) begin
                r_col <= col_t'(col_sel);
            end
            if (w_gnt_disp) begin
                r_dir <= ~r_dir;
            end
            if (w_gnt_lift) begin
                r_lift <= ~r_lift;
            end
            if (w_gnt) begin
                r_width <= w_target;
                r_srv   <= w_gnt_lift ? SRV_LIFT :
                           w_gnt_col  ? SRV_COL  : SRV_DISP;
            end
        end
    end

    assign w_move    = (r_state == ST_MOVE) & w_pulse;
    assign pwm_disp  = w_move & (r_srv == SRV_DISP);
    assign pwm_color = w_move & (r_srv == SRV_COL);
    assign pwm_lift  = w_move & (r_srv == SRV_LIFT);
    assign busy      = (r_state != ST_IDLE) | r_pend_go |
                       r_pend_col | r_pend_lift;
    assign done      = w_done;
    assign err       = r_err;

endmodule

// File: tb/tb_servo_sequencer.sv
// Bench for servo_sequencer: records every PWM pulse and compares it
// with a move list derived from priority and toggle rules.
module tb_servo_sequencer;

    localparam int FT = 1000;
    localparam int WL = 50;
    localparam int WM = 75;
    localparam int WR = 100;
    localparam int HF = 3;
    localparam int GF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       go, col_req, lift_req;
    logic [1:0] col_sel;
    logic       pwm_disp, pwm_color, pwm_lift, busy, done, err;

    always #5 clk = ~clk;

    servo_sequencer #(
        .FRAME_TICKS(FT), .W_LEFT(WL), .W_MID(WM), .W_RIGHT(WR),
        .HOLD_FRAMES(HF), .GAP_FRAMES(GF)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .col_req(col_req),
        .col_sel(col_sel), .lift_req(lift_req),
        .pwm_disp(pwm_disp), .pwm_color(pwm_color), .pwm_lift(pwm_lift),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        int srv;
        int width;
        int phase;
        int t;
    } pulse_t;

    pulse_t got_q[$];
    pulse_t exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int cyc      = 0;
    int ph       = 0;
    int m_dir    = 0;
    int m_lift   = 0;
    bit on_s[3];
    int len_s[3];
    int ph_s[3];
    int t_s[3];

    // Reference frame position: cycles since reset, modulo the frame.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) ph <= 0;
        else ph <= (ph == FT - 1) ? 0 : ph + 1;
    end

    always @(negedge clk) begin
        logic [2:0] p;
        pulse_t pu;
        p = {pwm_lift, pwm_color, pwm_disp};
        n_assert++;
        assert ($countones(p) <= 1) else begin
            n_fail++;
            $error("FAIL one_hot_pwm: observed %b expected at most one", p);
        end
        if (err) err_cnt++;
        for (int s = 0; s < 3; s++) begin
            if (p[s]) begin
                if (!on_s[s]) begin
                    ph_s[s]  = ph;
                    t_s[s]   = cyc;
                    len_s[s] = 0;
                end
                len_s[s]++;
            end else if (on_s[s]) begin
                pu.srv   = s;
                pu.width = len_s[s];
                pu.phase = ph_s[s];
                pu.t     = t_s[s];
                got_q.push_back(pu);
            end
            on_s[s] = p[s];
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic add_move(input int s, input int w);
        pulse_t pu;
        pu.srv   = s;
        pu.width = w;
        pu.phase = 0;
        pu.t     = 0;
        repeat (HF) exp_q.push_back(pu);
    endtask

    task automatic exp_disp();
        add_move(0, (m_dir != 0) ? WR : WL);
        m_dir ^= 1;
    endtask

    task automatic exp_lift();
        m_lift ^= 1;
        add_move(2, (m_lift != 0) ? WR : WL);
    endtask

    task automatic exp_col(input int sel);
        add_move(1, (sel == 0) ? WL : (sel == 1) ? WM : WR);
    endtask

    task automatic req(input logic g, input logic c, input logic l,
                       input logic [1:0] s);
        @(negedge clk);
        go = g; col_req = c; lift_req = l; col_sel = s;
        @(negedge clk);
        go = 1'b0; col_req = 1'b0; lift_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n,
                             output int busy_low);
        int k = 0;
        int b = 0;
        busy_low = 0;
        while (k < n && b < 7000 * n + 100) begin
            @(negedge clk);
            b++;
            if (done) k++;
            if (!busy) busy_low++;
        end
        check({tag, ".done_count"}, k, n);
        repeat (3) @(negedge clk);
        check({tag, ".busy_after"}, int'(busy), 0);
    endtask

    task automatic check_moves(input string tag);
        int n;
        check({tag, ".pulses"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.srv%0d", tag, i), got_q[i].srv, exp_q[i].srv);
            check($sformatf("%s.w%0d", tag, i), got_q[i].width, exp_q[i].width);
            check($sformatf("%s.ph%0d", tag, i), got_q[i].phase, 0);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int bl, t0, e0, hi, bd, mask, sel, nm;
        rst = 1'b1; go = 1'b0; col_req = 1'b0; lift_req = 1'b0;
        col_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("rst.pwm", int'({pwm_lift, pwm_color, pwm_disp}), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.done_err", int'({done, err}), 0);
        rst = 1'b0;

        // Single dispense move started mid-frame, then the return move.
        repeat ($urandom_range(100, 700)) @(negedge clk);
        t0 = cyc;
        req(1, 0, 0, 0);
        exp_disp();
        wait_done("disp1", 1, bl);
        check("disp1.busy_hold", bl, 0);
        if (got_q.size() > 0) begin
            t0 = got_q[0].t - t0;
            check("disp1.first_rise_next_wrap", int'(t0 > 0 && t0 <= FT), 1);
        end
        check_moves("disp1");
        req(1, 0, 0, 0);
        exp_disp();
        wait_done("disp2", 1, bl);
        check_moves("disp2");

        // Simultaneous requests are serviced by priority.
        repeat ($urandom_range(1, 900)) @(negedge clk);
        req(1, 1, 1, 2);
        exp_lift(); exp_col(2); exp_disp();
        wait_done("prio", 3, bl);
        check("prio.busy_hold", bl, 0);
        check_moves("prio");

        // Invalid colour is dropped with an error pulse only.
        e0 = err_cnt;
        hi = 0;
        req(0, 1, 0, 3);
        repeat (3000) begin
            @(negedge clk);
            if (busy) hi++;
        end
        check("badcol.err", err_cnt - e0, 1);
        check("badcol.busy", hi, 0);
        check_moves("badcol");

        // Colour requests merge while the dispenser moves.
        req(1, 0, 0, 0);
        exp_disp();
        bd = 0;
        while (!pwm_disp && bd < 3000) begin
            @(negedge clk);
            bd++;
        end
        check("merge.disp_started", int'(pwm_disp), 1);
        req(0, 1, 0, 0);
        repeat (200) @(negedge clk);
        req(0, 1, 0, 1);
        exp_col(1);
        wait_done("merge", 2, bl);
        check_moves("merge");

        // Reset in the second hold frame aborts the move.
        req(1, 0, 0, 0);
        bd = 0;
        while (!(got_q.size() >= 1 && pwm_disp) && bd < 4000) begin
            @(negedge clk);
            bd++;
        end
        check("rstmid.second_frame", int'(pwm_disp), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid.pwm", int'({pwm_lift, pwm_color, pwm_disp}), 0);
        check("rstmid.busy", int'(busy), 0);
        rst = 1'b0;
        m_dir = 0; m_lift = 0;
        repeat (3) @(negedge clk);
        got_q.delete();
        req(1, 0, 0, 0);
        exp_disp();
        wait_done("after_rst", 1, bl);
        check_moves("after_rst");

        // Random request mixes against the priority/toggle model.
        for (int it = 0; it < 2; it++) begin
            mask = $urandom_range(1, 7);
            sel  = $urandom_range(0, 3);
            repeat ($urandom_range(1, 900)) @(negedge clk);
            e0 = err_cnt;
            nm = 0;
            req(mask[0], mask[1], mask[2], sel[1:0]);
            if (mask[2]) begin exp_lift(); nm++; end
            if (mask[1] && sel != 3) begin exp_col(sel); nm++; end
            if (mask[0]) begin exp_disp(); nm++; end
            wait_done($sformatf("rnd%0d", it), nm, bl);
            check($sformatf("rnd%0d.err", it), err_cnt - e0,
                  (mask[1] && sel == 3) ? 1 : 0);
            check_moves($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
